// File: rtl/v_rams_frame_ctrl_if.sv
// Valid/ready word stream with an end-of-frame marker.
// The master drives valid/data/last; the slave returns ready.
interface v_rams_frame_ctrl_if #(
  parameter int DW = 16
);
  logic          valid;
  logic          ready;
  logic [DW-1:0] data;
  logic          last;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/v_rams_frame_ctrl.sv
// Frame buffer in front of a single-port RAM: fill until end-of-frame, one PRIME cycle, then drain in order.
// 2-cycle latency from the closing word to the first output word; output stalls freeze the RAM read address.
module v_rams_frame_ctrl #(
  parameter int AW    = 6,
  parameter int DW    = 16,
  parameter int DEPTH = 2**AW
) (
  input  logic                clk,
  input  logic                rst,
  v_rams_frame_ctrl_if.slave  in_stream,
  v_rams_frame_ctrl_if.master out_stream,
  output logic [AW:0]         frame_len,
  output logic                ram_en,
  output logic                ram_we,
  output logic [AW-1:0]       ram_addr,
  output logic [DW-1:0]       ram_di,
  input  logic [DW-1:0]       ram_do
);

  localparam logic [1:0] FILL  = 2'd0;
  localparam logic [1:0] PRIME = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  localparam logic [AW:0]   LAST_IDX = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0]   ONE_W    = (AW+1)'(1);
  localparam logic [AW-1:0] ONE_R    = AW'(1);

  logic [1:0]    state;
  logic [AW:0]   wr_ptr;
  logic [AW-1:0] rd_ptr;

  logic in_fill;
  logic in_prime;
  logic in_drain;
  logic fill_acc;
  logic frame_close;
  logic drain_last;

  // Outputs are gated with rst so they drop the moment reset asserts.
  assign in_fill     = (state == FILL)  && !rst;
  assign in_prime    = (state == PRIME) && !rst;
  assign in_drain    = (state == DRAIN) && !rst;
  assign fill_acc    = in_fill && in_stream.valid;
  assign frame_close = in_stream.last || (wr_ptr == LAST_IDX);
  assign drain_last  = in_drain && ({1'b0, rd_ptr} == (frame_len - ONE_W));

  assign in_stream.ready  = in_fill;
  assign out_stream.valid = in_drain;
  assign out_stream.last  = drain_last;
  assign out_stream.data  = ram_do;

  always_comb begin
    ram_en   = 1'b0;
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_di   = '0;
    if (fill_acc) begin
      ram_en   = 1'b1;
      ram_we   = 1'b1;
      ram_addr = wr_ptr[AW-1:0];
      ram_di   = in_stream.data;
    end else if (in_prime) begin
      ram_en   = 1'b1;
    end else if (in_drain && out_stream.ready && !drain_last) begin
      // Advance the registered read address only on a handshake.
      ram_en   = 1'b1;
      ram_addr = rd_ptr + ONE_R;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= FILL;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      frame_len <= '0;
    end else begin
      case (state)
        FILL: begin
          if (fill_acc) begin
            wr_ptr <= wr_ptr + ONE_W;
            if (frame_close) begin
              frame_len <= wr_ptr + ONE_W;
              state     <= PRIME;
            end
          end
        end
        PRIME: begin
          rd_ptr <= '0;
          state  <= DRAIN;
        end
        DRAIN: begin
          if (out_stream.ready) begin
            if (drain_last) begin
              wr_ptr <= '0;
              state  <= FILL;
            end else begin
              rd_ptr <= rd_ptr + ONE_R;
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule
